spi_alu_slave: RTL
==================

// Module: spi_alu_slave
// PURPOSE
//  Parametrised SPI-slave ALU for the processor's execute stage; the processor is SPI master.
//  Receives one request frame {op_2, op_1, op_code} serially, computes one result and returns {flags, result}.
//  Adds generic width, eight operations, a status-flag word, illegal-opcode error, NSS abort and response timeout.
// PARAMETERS
//  DATA_WIDTH     8   operand/result width, >= 2
//  OPCODE_WIDTH   4   opcode field width, >= 3; codes 0..7 legal, all others illegal
//  TIMEOUT_CYCLES 64  max cycles in SEND waiting for the master ack; 0 disables the timeout
// PORTS
//  i_clock   in   1   system clock; all state changes on rising edge
//  i_reset   in   1   asynchronous, active-high reset
//  i_nss     in   1   slave select, active low
//  i_mosi    in   1   master-out serial data / handshake
//  o_miso    out  1   slave-out serial data / handshake; forced 0 whenever i_nss=1
//  o_busy    out  1   1 in any state other than IDLE
//  o_done    out  1   one-cycle pulse on the last SENDING cycle
//  o_error   out  1   one-cycle pulse on abort (NSS rise) or timeout
// BEHAVIOUR
//  Reset (async, i_reset=1): state IDLE, all counters, request and response registers 0; o_miso=o_busy=o_done=o_error=0.
//  Sizes: REQ_BITS = OPCODE_WIDTH + 2*DATA_WIDTH; RSP_BITS = DATA_WIDTH + 5. Both frames LSB-first.
//  Request: op_code in bits [OPCODE_WIDTH-1:0], then op_1, then op_2.
//  Response: bits [DATA_WIDTH-1:0] = result, then flags Z, N, C, V, E.
//  States / transitions:
//   IDLE      -> RECEIVING when i_nss=0 && i_mosi=1 && o_miso=0 (start bit, cycle t).
//   RECEIVING samples i_mosi into request bit [cnt] on cycles t+1 .. t+REQ_BITS.
//             -> OPERATE after bit REQ_BITS-1 is sampled; cnt returns to 0.
//   OPERATE   one cycle: result and flags are registered -> SEND.
//   SEND      o_miso=1. -> SENDING when i_mosi=0. -> IDLE with o_error pulse when the timeout counter reaches TIMEOUT_CYCLES.
//   SENDING   o_miso = response[cnt], cnt +1 per cycle, RSP_BITS cycles. After the last bit: -> IDLE, o_done pulse.
//  Abort: i_nss=1 in any non-IDLE state -> IDLE on the next edge, counters cleared, o_error pulse; no partial result kept.
//  Ops (signed ops use two's complement):
//   0 ADD, 1 SUB (op_1-op_2), 2 AND, 3 OR, 4 XOR,
//   5 SLT: result = {0..,1} if signed op_1 < op_2, else 0,
//   6 SHL: op_1 << op_2[$clog2(DATA_WIDTH)-1:0],
//   7 SHR: logical shift right, same shift-amount field.
//  Flags:
//   Z = (result == 0); N = result[MSB].
//   C = carry-out (ADD) or NOT borrow (SUB); 0 for every other op.
//   V = signed overflow (ADD/SUB only); 0 for every other op.
//   E = illegal opcode; result forced to 0, Z=1.
//  ADD/SUB computed at DATA_WIDTH+1 bits; the result is truncated to DATA_WIDTH.
//  Latency: start bit to first response bit = REQ_BITS + 2 cycles + master ack delay.
//  Back-to-back frames: a new start bit is accepted on the cycle after SENDING ends.
//  i_mosi is ignored in OPERATE and SENDING. i_nss held low across frames is legal.
// TESTING (DATA_WIDTH=8, OPCODE_WIDTH=4)
//  ADD: op_1=0xF0, op_2=0x20 -> result 0x10; C=1, Z=0, N=0, V=0, E=0; o_done pulses once.
//  SUB: 0x05-0x05 -> 0x00, Z=1, C=1. SUB: 0x7F-0xFF -> 0x80, V=1, N=1.
//  SLT: 0x80 vs 0x01 -> 0x01. SHL: 0x81, op_2=0x09 -> 0x02. SHR: 0x80, op_2=3 -> 0x10.
//  Illegal opcode 9 with any operands -> result 0x00, E=1, Z=1.
//  NSS abort: raise i_nss after 5 request bits -> IDLE next cycle, o_error pulse, o_miso=0; next full ADD frame correct.
//  Timeout: hold i_mosi=1 in SEND -> IDLE with o_error after 64 cycles. Async reset asserted mid-SENDING -> all outputs 0 immediately.

Source files
------------

// File: rtl/spi_alu_slave.sv
// SPI-slave ALU.
// The processor (SPI master) shifts in one request frame {op_2, op_1, op_code},
// LSB first. The slave computes one result and shifts back {flags, result},
// also LSB first. Flags are {E, V, C, N, Z}, with Z just above the result MSB.
//
// Handshake:
//   - The master raises i_mosi while the slave is idle to send a start bit.
//   - Once the result is ready, the slave raises o_miso.
//   - The master acknowledges by pulling i_mosi low, and the response follows.
//   - Raising i_nss at any point abandons the frame.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for a start bit (i_nss low, i_mosi high)
// RECEIVING  | shifting in REQ_BITS request bits, one per cycle
// OPERATE    | single cycle: ALU result and flags captured
// SEND       | o_miso held high until the master acks with i_mosi low
// SENDING    | shifting out RSP_BITS response bits on o_miso

module spi_alu_slave #(
    parameter int DATA_WIDTH     = 8,
    parameter int OPCODE_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_nss,
    input  logic i_mosi,
    output logic o_miso,
    output logic o_busy,
    output logic o_done,
    output logic o_error
);

    localparam int REQ_BITS = OPCODE_WIDTH + 2 * DATA_WIDTH;
    localparam int RSP_BITS = DATA_WIDTH + 5;

    // The request is always at least as long as the response, so one bit
    // counter sized for the request covers both phases.
    localparam int CNT_W = $clog2(REQ_BITS);
    localparam logic [CNT_W-1:0] REQ_LAST = CNT_W'(REQ_BITS - 1);
    localparam logic [CNT_W-1:0] RSP_LAST = CNT_W'(RSP_BITS - 1);

    localparam int SH_W = $clog2(DATA_WIDTH);
    localparam int MSB  = DATA_WIDTH - 1;

    // The ack timer counts down from TIMEOUT_CYCLES-1 and expires on the
    // SEND cycle where it reads zero. That gives exactly TIMEOUT_CYCLES
    // cycles of waiting.
    localparam bit TO_EN      = (TIMEOUT_CYCLES > 0);
    localparam int TO_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LOAD_I  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TO_LOAD_I);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RECEIVING = 3'd1;
    localparam logic [2:0] ST_OPERATE   = 3'd2;
    localparam logic [2:0] ST_SEND      = 3'd3;
    localparam logic [2:0] ST_SENDING   = 3'd4;

    logic [2:0]          state;
    logic [2:0]          state_nxt;
    logic [CNT_W-1:0]    bit_cnt;
    logic [TO_W-1:0]     to_cnt;
    logic [REQ_BITS-1:0] req;
    logic [RSP_BITS-1:0] rsp;
    logic [RSP_BITS-1:0] rsp_nxt;
    logic                err_q;

    logic                    abort;
    logic                    timeout;
    logic [OPCODE_WIDTH-1:0] op_code;
    logic [DATA_WIDTH-1:0]   op_1;
    logic [DATA_WIDTH-1:0]   op_2;

    assign op_code = req[OPCODE_WIDTH-1:0];
    assign op_1    = req[OPCODE_WIDTH +: DATA_WIDTH];
    assign op_2    = req[OPCODE_WIDTH + DATA_WIDTH +: DATA_WIDTH];

    // Deselect wins over everything once a frame is in progress.
    assign abort = i_nss && (state != ST_IDLE);

    assign timeout = TO_EN && !i_nss && (state == ST_SEND) && i_mosi
                     && (to_cnt == '0);

    // Next-state selection; abort overrides the per-state transitions.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!i_nss && i_mosi && !o_miso) begin
                    state_nxt = ST_RECEIVING;
                end
            end
            ST_RECEIVING: begin
                if (bit_cnt == REQ_LAST) begin
                    state_nxt = ST_OPERATE;
                end
            end
            ST_OPERATE: begin
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (!i_mosi) begin
                    state_nxt = ST_SENDING;
                end else if (timeout) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SENDING: begin
                if (bit_cnt == RSP_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (abort) begin
            state_nxt = ST_IDLE;
        end
    end

    // State register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bit index within the current request or response frame.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            bit_cnt <= '0;
        end else if (abort) begin
            bit_cnt <= '0;
        end else if (state == ST_RECEIVING) begin
            bit_cnt <= (bit_cnt == REQ_LAST) ? '0 : bit_cnt + 1'b1;
        end else if (state == ST_SENDING) begin
            bit_cnt <= (bit_cnt == RSP_LAST) ? '0 : bit_cnt + 1'b1;
        end else begin
            bit_cnt <= '0;
        end
    end

    // Ack-timeout down-counter: loaded while operating, counts during SEND.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            to_cnt <= '0;
        end else if (abort) begin
            to_cnt <= '0;
        end else if (state == ST_OPERATE) begin
            to_cnt <= TO_LOAD;
        end else if (state == ST_SEND) begin
            if (to_cnt != '0) begin
                to_cnt <= to_cnt - 1'b1;
            end
        end else begin
            to_cnt <= '0;
        end
    end

    // Request shift register: bits arrive LSB first and enter at the top,
    // so after REQ_BITS shifts the first bit sits at position 0.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            req <= '0;
        end else if (abort) begin
            req <= '0;
        end else if (state == ST_RECEIVING) begin
            req <= {i_mosi, req[REQ_BITS-1:1]};
        end
    end

    // ALU: computes the result and the {E, V, C, N, Z} flags from the request.
    always_comb begin
        logic [DATA_WIDTH:0]   wide;
        logic [DATA_WIDTH-1:0] res;
        logic                  f_c;
        logic                  f_v;
        logic                  f_e;

        wide = '0;
        res  = '0;
        f_c  = 1'b0;
        f_v  = 1'b0;
        f_e  = 1'b0;

        case (op_code[2:0])
            3'd0: begin
                wide = {1'b0, op_1} + {1'b0, op_2};
                res  = wide[DATA_WIDTH-1:0];
                f_c  = wide[DATA_WIDTH];
                f_v  = (op_1[MSB] == op_2[MSB]) && (res[MSB] != op_1[MSB]);
            end
            3'd1: begin
                // The extra top bit is the borrow; C reports its inverse.
                wide = {1'b0, op_1} - {1'b0, op_2};
                res  = wide[DATA_WIDTH-1:0];
                f_c  = ~wide[DATA_WIDTH];
                f_v  = (op_1[MSB] != op_2[MSB]) && (res[MSB] != op_1[MSB]);
            end
            3'd2: res = op_1 & op_2;
            3'd3: res = op_1 | op_2;
            3'd4: res = op_1 ^ op_2;
            3'd5: res[0] = ($signed(op_1) < $signed(op_2));
            3'd6: res = op_1 << op_2[SH_W-1:0];
            3'd7: res = op_1 >> op_2[SH_W-1:0];
            default: res = '0;
        endcase

        // Opcodes above 7 are illegal: the result is forced to 0 and only
        // E and Z are reported.
        if (op_code > OPCODE_WIDTH'(7)) begin
            res = '0;
            f_c = 1'b0;
            f_v = 1'b0;
            f_e = 1'b1;
        end

        rsp_nxt = {f_e, f_v, f_c, res[MSB], (res == '0), res};
    end

    // Response register: captured in OPERATE, then shifted out LSB first.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            rsp <= '0;
        end else if (abort) begin
            rsp <= '0;
        end else if (state == ST_OPERATE) begin
            rsp <= rsp_nxt;
        end else if (state == ST_SENDING) begin
            rsp <= {1'b0, rsp[RSP_BITS-1:1]};
        end
    end

    // Error pulse, issued in the first IDLE cycle after an abort or timeout.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= abort || timeout;
        end
    end

    // o_miso follows i_nss directly, so a deselected slave releases the
    // line within the same cycle.
    assign o_miso  = !i_nss && ((state == ST_SEND) || ((state == ST_SENDING) && rsp[0]));
    assign o_busy  = (state != ST_IDLE);
    assign o_done  = !i_nss && (state == ST_SENDING) && (bit_cnt == RSP_LAST);
    assign o_error = err_q;

endmodule
